// File: rtl/rv32i_seq_multiplier_16x16.sv
// -----------------------------------------------------------------------------
// rv32i_seq_multiplier_16x16
//
// Sequential 16x16 -> 32 unsigned shift-and-add multiplier for the RV32I
// multiply/shift control path.
//
// Operation
//   IDLE : waits for i_en. On a start it captures the operands, clears the
//          accumulator and the step counter, and moves to BUSY.
//   BUSY : one multiplier bit per cycle. When multiplier[0] is set, the
//          shifted multiplicand is added to the accumulator. The multiplicand
//          then shifts left and the multiplier shifts right.
//   DONE : o_valid is high for exactly one cycle. The FSM then returns to
//          IDLE unconditionally.
//
// Results and status
//   o_result is loaded only on the BUSY->DONE edge, so a partial product is
//   never visible. o_result holds its value until the next completion.
//   o_valid and o_busy are both registered and are never high together.
//
// Reset
//   i_rst is asynchronous and active-high. It clears all state and outputs,
//   so an aborted operation produces no valid pulse.
//
// Build option
//   MULT_EARLY_TERM_EN : when defined, BUSY ends on the first step that leaves
//   the shifted multiplier at zero. Latency is then max(1, p+1) cycles, where
//   p is the index of the highest set bit of the multiplier. The product is
//   the same in both builds.
//   Default build (macro undefined): BUSY always lasts 16 cycles.
// -----------------------------------------------------------------------------
module rv32i_seq_multiplier_16x16 (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic [15:0] i_operand_one,
    input  logic [15:0] i_operand_two,
    output logic        o_valid,
    output logic [31:0] o_result,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [4:0] LAST_STEP = 5'd16;

    // Registered state
    state_e      state_q;
    logic [31:0] mcand_q;
    logic [15:0] mplier_q;
    logic [31:0] acc_q;
    logic [4:0]  cnt_q;
    logic [31:0] result_q;
    logic        valid_q;
    logic        busy_q;

    // Next-state values
    state_e      state_d;
    logic [31:0] mcand_d;
    logic [15:0] mplier_d;
    logic [31:0] acc_d;
    logic [4:0]  cnt_d;
    logic [31:0] result_d;
    logic        valid_d;
    logic        busy_d;

    // Datapath for one BUSY step
    logic [31:0] step_add_s;
    logic [31:0] acc_sum_s;
    logic [31:0] mcand_shift_s;
    logic [15:0] mplier_shift_s;
    logic [4:0]  cnt_inc_s;
    logic        last_step_s;

    // One shift-and-add step. The sum cannot overflow 32 bits for
    // 16-bit operands.
    always_comb begin
        step_add_s     = mplier_q[0] ? mcand_q : 32'd0;
        acc_sum_s      = acc_q + step_add_s;
        mcand_shift_s  = {mcand_q[30:0], 1'b0};
        mplier_shift_s = {1'b0, mplier_q[15:1]};
        cnt_inc_s      = cnt_q + 5'd1;
`ifdef MULT_EARLY_TERM_EN
        // Stop once no multiplier bits remain. The step-16 check is
        // kept as a hard upper bound.
        last_step_s    = (mplier_shift_s == 16'd0) || (cnt_inc_s == LAST_STEP);
`else
        last_step_s    = (cnt_inc_s == LAST_STEP);
`endif
    end

    // FSM next-state and registered-output decode
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        valid_d  = 1'b0;
        busy_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_en) begin
                    mcand_d  = {16'd0, i_operand_one};
                    mplier_d = i_operand_two;
                    acc_d    = 32'd0;
                    cnt_d    = 5'd0;
                    state_d  = ST_BUSY;
                    busy_d   = 1'b1;
                end else begin
                    state_d  = ST_IDLE;
                    busy_d   = 1'b0;
                end
            end

            ST_BUSY: begin
                acc_d    = acc_sum_s;
                mcand_d  = mcand_shift_s;
                mplier_d = mplier_shift_s;
                cnt_d    = cnt_inc_s;
                if (last_step_s) begin
                    state_d  = ST_DONE;
                    result_d = acc_sum_s;
                    valid_d  = 1'b1;
                    busy_d   = 1'b0;
                end else begin
                    state_d  = ST_BUSY;
                    busy_d   = 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end

            default: begin
                // The unused encoding recovers to IDLE without a result.
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            mcand_q  <= 32'd0;
            mplier_q <= 16'd0;
            acc_q    <= 32'd0;
            cnt_q    <= 5'd0;
            result_q <= 32'd0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign o_valid  = valid_q;
    assign o_result = result_q;
    assign o_busy   = busy_q;

endmodule

// File: tb/tb_rv32i_seq_multiplier_16x16.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for rv32i_seq_multiplier_16x16.
//
// Clock period is 10 time units. Inputs change 1 unit after each rising
// edge, and outputs are sampled at that same point.
//
// Expected latencies follow MULT_EARLY_TERM_EN when it is defined for
// this bench.
// -----------------------------------------------------------------------------
module tb_rv32i_seq_multiplier_16x16;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] op_one;
    logic [15:0] op_two;
    logic        valid;
    logic [31:0] result;
    logic        busy;

    int n_checks;
    int n_bad;
    int lat;
    int gap;
    int saw_valid;

    rv32i_seq_multiplier_16x16 dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_en          (en),
        .i_operand_one (op_one),
        .i_operand_two (op_two),
        .o_valid       (valid),
        .o_result      (result),
        .o_busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start one operation, wait (bounded) for o_valid, then check latency,
    // product and the status outputs around the DONE cycle.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp_prod, input int exp_lat);
        en     = 1'b1;
        op_one = a;
        op_two = b;
        tick();
        en = 1'b0;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        lat = 0;
        while (valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_prod"}, result, exp_prod);
        check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
        tick();
        check({tag, "_valid_pulse"}, {31'd0, valid}, 32'd0);
        check({tag, "_hold"}, result, exp_prod);
    endtask

`ifdef MULT_EARLY_TERM_EN
    localparam int LAT_0056 = 7;
    localparam int LAT_0000 = 1;
    localparam int LAT_0001 = 1;
    localparam int LAT_0003 = 2;
    localparam int LAT_0020 = 6;
`else
    localparam int LAT_0056 = 16;
    localparam int LAT_0000 = 16;
    localparam int LAT_0001 = 16;
    localparam int LAT_0003 = 16;
    localparam int LAT_0020 = 16;
`endif

    initial begin
        n_checks = 0;
        n_bad    = 0;
        rst      = 1'b1;
        en       = 1'b0;
        op_one   = 16'd0;
        op_two   = 16'd0;
        tick();
        tick();
        check("rst_valid",  {31'd0, valid}, 32'd0);
        check("rst_busy",   {31'd0, busy},  32'd0);
        check("rst_result", result,         32'd0);
        rst = 1'b0;
        tick();
        check("idle_busy", {31'd0, busy}, 32'd0);

        run_op("p1234x0056", 16'h1234, 16'h0056, 32'h0006_1D78, LAT_0056);
        run_op("pFFFFxFFFF", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 16);
        run_op("pABCDx0000", 16'hABCD, 16'h0000, 32'h0000_0000, LAT_0000);
        run_op("p0003x0001", 16'h0003, 16'h0001, 32'h0000_0003, LAT_0001);

        // Idle with i_en low: result holds, nothing starts
        op_one = 16'h5555;
        op_two = 16'h7777;
        for (int i = 0; i < 5; i++) tick();
        check("idle_hold_result", result, 32'h0000_0003);
        check("idle_hold_busy", {31'd0, busy}, 32'd0);

        // Abort on BUSY cycle 5
        en     = 1'b1;
        op_one = 16'h00FF;
        op_two = 16'h0102;
        tick();
        en = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy",   {31'd0, busy},  32'd0);
        check("abort_valid",  {31'd0, valid}, 32'd0);
        check("abort_result", result,         32'd0);
        tick();
        rst = 1'b0;
        saw_valid = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (valid === 1'b1) saw_valid = 1;
        end
        check("abort_no_valid", saw_valid, 0);
        check("abort_idle", {31'd0, busy}, 32'd0);
        run_op("p0002x0003", 16'h0002, 16'h0003, 32'h0000_0006, LAT_0003);

        // Back-to-back with i_en held high and operands changed mid-BUSY
        en     = 1'b1;
        op_one = 16'h0010;
        op_two = 16'h0020;
        tick();
        tick();
        op_one = 16'hFFFF;
        op_two = 16'hFFFF;
        lat = 1;
        while (valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        check("b2b_first_lat",  lat,    LAT_0020);
        check("b2b_first_prod", result, 32'h0000_0200);
        check("b2b_excl", {31'd0, busy}, 32'd0);
        gap = 0;
        do begin
            tick();
            gap++;
        end while (valid !== 1'b1 && gap < 40);
        check("b2b_gap",         gap,    18);
        check("b2b_second_prod", result, 32'hFFFE_0001);
        en = 1'b0;
        tick();
        check("b2b_end_valid", {31'd0, valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
